// File: rtl/disp_pkg.sv
// Shared types, sizes and helpers for the 4-digit multiplexed display scanner.
// Holds the FSM state enum, the double-dabble adjust step and digit selection with blanking.
package disp_pkg;

  localparam int N_DIGITS = 4;
  localparam int BIN_W = 14;
  localparam int MAX_VAL = 9999;
  localparam int BCD_W = 4 * N_DIGITS;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LATCH
  } state_t;

  // Add-3 correction applied to every nibble before each double-dabble shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic [3:0] nib;
    res = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      nib = bcd[i*4 +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      res[i*4 +: 4] = nib;
    end
    return res;
  endfunction

  // A digit above the units is blanked only when it and every more significant digit are zero.
  function automatic logic [3:0] pick_digit(input logic [BCD_W-1:0] disp,
                                            input logic [1:0] idx,
                                            input logic blank_lz);
    logic zero_above;
    zero_above = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(idx) && disp[i*4 +: 4] != 4'd0) zero_above = 1'b0;
    end
    if (blank_lz && idx != 2'd0 && zero_above) return BLANK_CODE;
    return disp[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/disp_scan_tick.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and pulses tick for one cycle at terminal count.
module scan_tick #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// Binary-to-BCD converter (sequential double-dabble, 14 cycles) driving a 4-digit multiplexed display.
// Anode select and digit code are registered together from next-state values, so updates land on the latch edge.
module disp_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid,
  output logic             bin_ready,
  output logic [3:0]       digit_bcd,
  output logic [3:0]       an,
  output logic             ovf
);

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);
  localparam logic [3:0] LAST_STEP = 4'(BIN_W - 1);

  state_t           state, state_nxt;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_sh;
  logic [3:0]       step_cnt;
  logic [BCD_W-1:0] disp, disp_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [3:0]       an_nxt;
  logic             tick;

  scan_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign bin_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bin_valid) state_nxt = CONVERT;
      CONVERT: if (step_cnt == LAST_STEP) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    disp_nxt = (state == LATCH) ? bcd_sh : disp;
    idx_nxt  = tick ? idx + 2'd1 : idx;
    an_nxt   = ~(4'b0001 << idx_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_sh    <= '0;
      bcd_sh    <= '0;
      step_cnt  <= '0;
      disp      <= '0;
      idx       <= '0;
      an        <= 4'b1110;
      digit_bcd <= 4'd0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      disp      <= disp_nxt;
      idx       <= idx_nxt;
      an        <= an_nxt;
      digit_bcd <= pick_digit(disp_nxt, idx_nxt, BLANK_LZ != 0);
      case (state)
        IDLE: begin
          if (bin_valid) begin
            bin_sh   <= (bin_in > MAX_BIN) ? MAX_BIN : bin_in;
            ovf      <= (bin_in > MAX_BIN);
            bcd_sh   <= '0;
            step_cnt <= '0;
          end
        end
        CONVERT: begin
          {bcd_sh, bin_sh} <= {dd_adjust(bcd_sh), bin_sh} << 1;
          step_cnt         <= step_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Drives two scanners (blanking on/off) with directed and random values and compares every cycle to a decimal model.
module tb_disp_scan;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bin_valid = 1'b0;
  logic [13:0] bin_in = '0;
  logic        ready_lz, ready_nz, ovf_lz, ovf_nz;
  logic [3:0]  dig_lz, dig_nz, an_lz, an_nz;

  always #5 clk = ~clk;

  disp_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) u_lz (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(ready_lz), .digit_bcd(dig_lz), .an(an_lz), .ovf(ovf_lz)
  );

  disp_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) u_nz (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(ready_nz), .digit_bcd(dig_nz), .an(an_nz), .ovf(ovf_nz)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: displayed decimal value, pending value, busy countdown, edges since reset.
  int m_disp = 0, m_pend = 0, m_busy = 0, m_k = 0;
  bit m_ovf = 0;
  bit armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_disp = 0; m_busy = 0; m_k = 0; m_ovf = 0; armed = 1;
    end else begin
      m_k++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_disp = m_pend;
      end else if (bin_valid) begin
        m_pend = (int'(bin_in) > 9999) ? 9999 : int'(bin_in);
        m_ovf  = int'(bin_in) > 9999;
        m_busy = 15;
      end
    end
  end

  function automatic int exp_digit(input int val, input int i, input bit lz);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (lz && i > 0 && val < p) return 15;
    return (val / p) % 10;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      int idx;
      idx = (m_k / DIV) % 4;
      chk("an_lz", int'(an_lz), int'(~(4'b0001 << idx) & 4'hF));
      chk("an_nz", int'(an_nz), int'(~(4'b0001 << idx) & 4'hF));
      chk("digit_lz", int'(dig_lz), exp_digit(m_disp, idx, 1'b1));
      chk("digit_nz", int'(dig_nz), exp_digit(m_disp, idx, 1'b0));
      chk("ready", int'(ready_lz), int'(m_busy == 0));
      chk("ready_nz", int'(ready_nz), int'(m_busy == 0));
      chk("ovf", int'(ovf_lz), int'(m_ovf));
      chk("ovf_nz", int'(ovf_nz), int'(m_ovf));
    end
  end

  task automatic cyc(input bit r, input bit v, input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r;
      bin_valid = v;
      bin_in = 14'(d);
    end
  endtask

  task automatic show(input int val);
    cyc(0, 1, val, 1);
    cyc(0, 0, 0, 15 + 4 * DIV + 2);
  endtask

  initial begin
    bit r, v;
    int d;
    cyc(1, 0, 0, 3);
    cyc(0, 0, 0, 4 * DIV + 2);
    show(1234);
    show(42);
    show(1005);
    show(0);
    show(12000);
    show(5);
    cyc(0, 1, 1111, 1);
    cyc(0, 1, 7777, 20);
    cyc(0, 0, 0, 33);
    cyc(0, 1, 9999, 1);
    cyc(0, 0, 0, 5);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 20);
    repeat (60) begin
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(0, 9);
        1:       d = $urandom_range(0, 999);
        2:       d = $urandom_range(0, 9999);
        default: d = $urandom_range(0, 16383);
      endcase
      cyc(r, v, d, $urandom_range(1, 24));
    end
    cyc(0, 0, 0, 34);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit stays lit (min 2).
REQ-002 SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bin_in  input  14  unsigned binary value to display.
REQ-006 SHALL have port bin_valid  input  1  bin_in valid this cycle.
REQ-007 SHALL have port bin_ready  output  1  block can accept a value.
REQ-008 SHALL have port digit_bcd  output  4  BCD code of currently scanned digit, to 7-segment decoder.
REQ-009 SHALL have port an  output  4  active-low one-hot anode select, bit i = digit i (0 = units).
REQ-010 SHALL have port ovf  output  1  last accepted value exceeded 9999.

Function
REQ-011 SHALL use FSM states IDLE, CONVERT, LATCH; bin_ready = 1 exactly when state is IDLE.
REQ-012 SHALL accept a value on a rising edge with bin_valid=1, bin_ready=1 and rst=0, then enter CONVERT.
REQ-013 SHALL saturate values >9999 to 9999 on acceptance, set ovf=1; any value <=9999 accepted clears ovf.
REQ-014 SHALL convert with sequential double-dabble: per CONVERT cycle, add 3 to each BCD nibble >=5, then shift left 1; exactly 14 cycles.
REQ-015 SHALL go CONVERT->LATCH after 14th shift, LATCH->IDLE after one cycle, copying four BCD nibbles into display registers on that edge.
REQ-016 SHALL hold bin_ready low for exactly 15 cycles after the accepting edge; new digits visible from the 15th edge on.
REQ-017 SHALL ignore bin_valid while not IDLE; no queuing of values.
REQ-018 SHALL keep scanning old display registers during CONVERT/LATCH; no glitch or blank.
REQ-019 SHALL run a prescaler 0..REFRESH_DIV-1, one-cycle tick at terminal count, then wrap to 0.
REQ-020 SHALL advance scan index 0->1->2->3->0 on each tick; an drives low only bit[index].
REQ-021 SHALL output digit_bcd = display digit[index], or 4'hF (blank code, decoder turns segments off) when blanked.
REQ-022 SHALL, when BLANK_LZ=1, blank digit i (i=3..1) if it and every higher digit are zero; digit 0 never blanked; interior zeros never blanked.
REQ-023 SHALL change an and digit_bcd on the same edge (registered together).

Reset
REQ-024 SHALL on rst=1: state IDLE, bin_ready=1, display digits 0, prescaler 0, index 0, an=4'b1110, digit_bcd=0, ovf=0.
REQ-025 SHALL abort an in-progress conversion on rst, leaving display at 0, no partial latch.
REQ-026 SHALL not accept a value on any edge where rst=1.

Structure
REQ-027 SHALL place in shared package disp_pkg: state enum, N_DIGITS=4, BIN_W=14, MAX_VAL=9999, BLANK_CODE=4'hF.
REQ-028 SHALL isolate prescaler in one sub-module scan_tick (parameter REFRESH_DIV, ports clk, rst, tick).
REQ-029 SHALL contain no combinational path from bin_in/bin_valid to an/digit_bcd.

Verification (REFRESH_DIV=4)
REQ-030 SHALL check reset: an=1110, digit_bcd=0, bin_ready=1; scan then shows 0,F,F,F on indices 0..3.
REQ-031 SHALL check 1234 accepted -> bin_ready low 15 cycles; then index 0..3 yields 4,3,2,1; an steps 1110,1101,1011,0111 every 4 cycles.
REQ-032 SHALL check blanking: 42 -> 2,4,F,F; 1005 -> 5,0,0,1; 0 -> 0,F,F,F; BLANK_LZ=0 with 42 -> 2,4,0,0.
REQ-033 SHALL check 12000 -> shows 9,9,9,9 with ovf=1; then 5 -> 5,F,F,F with ovf=0.
REQ-034 SHALL check bin_valid held with 7777 during conversion of 1111 -> display 1111 only; 7777 accepted only once ready returns high.
REQ-035 SHALL check rst pulsed at CONVERT cycle 6 of 9999 -> display 0, an=1110, bin_ready=1 next cycle.
